// File: rtl/spi_slave_responder.sv
// spi_slave_responder
// SPI mode 0 responder, MSB first, one DATA_WIDTH-bit word per cs_bar frame.
// The SPI pins are asynchronous to clk. They are oversampled through synchronizer
// chains, and all edges are detected in the clk domain.
//
// Ports
//   clk        system clock
//   reset      asynchronous active-low reset
//   sclk       SPI clock from master
//   cs_bar     chip select from master, active-low
//   mosi       serial data from master
//   miso       serial data to master (0 when not driven)
//   miso_oe    miso drive enable
//   tx_data    word to send in a following frame
//   tx_load    tx_data valid, accepted while tx_ready=1
//   tx_ready   tx holding buffer empty
//   rx_data    last complete received word
//   rx_valid   1-cycle pulse, rx_data updated
//   tx_done    1-cycle pulse, complete frame closed by cs_bar rise
//   frame_err  1-cycle pulse, cs_bar rose mid-word
//   busy       frame in progress
//
// state   | meaning
// IDLE    | no frame, waiting for cs_bar fall (only once armed)
// SHIFT   | frame open, shifting bits
// WAIT_CS | full word received, waiting for cs_bar rise

module spi_slave_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_bar,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_done,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
  localparam int INIT_W = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
  logic                    sclk_prev, cs_prev;
  logic [INIT_W-1:0]       init_cnt;
  logic                    armed;
  logic [DATA_WIDTH-1:0]   tx_buf, shift_out, shift_in;
  logic                    tx_full;
  logic [CNT_W-1:0]        bit_cnt;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  assign busy     = (state != IDLE);
  assign miso_oe  = ~cs_s & (state != IDLE);
  assign miso     = miso_oe & shift_out[DATA_WIDTH-1];
  assign tx_ready = ~tx_full;

  // Synchronizers preset to the idle bus levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_bar};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  // The preset chain drains to the real pin level only after reset. Frames are
  // armed once the flushed chain shows cs_bar high. If cs_bar is held low through
  // reset release, this ignores the spurious fall and waits for a real rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_cnt <= INIT_W'(SYNC_STAGES + 1);
      armed    <= 1'b0;
    end else begin
      if (init_cnt != '0) init_cnt <= init_cnt - 1'b1;
      else if (cs_s)      armed    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx_buf    <= '0;
      tx_full   <= 1'b0;
      shift_out <= '0;
      shift_in  <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_done   <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE && cs_fall && armed) begin
        state   <= SHIFT;
        bit_cnt <= '0;
        if (tx_full) begin
          shift_out <= tx_buf;
          tx_full   <= 1'b0;
        end else if (tx_load) begin
          // A word loaded in the same cycle goes straight to the shifter.
          shift_out <= tx_data;
        end else begin
          shift_out <= '0;
        end
      end else if (tx_load && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end

      case (state)
        SHIFT: begin
          if (cs_rise) begin
            if (bit_cnt != '0) frame_err <= 1'b1;
            state <= IDLE;
          end else if (sclk_rise) begin
            shift_in <= {shift_in[DATA_WIDTH-2:0], mosi_s};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              rx_data  <= {shift_in[DATA_WIDTH-2:0], mosi_s};
              rx_valid <= 1'b1;
              state    <= WAIT_CS;
            end
          end else if (sclk_fall && bit_cnt != '0) begin
            shift_out <= {shift_out[DATA_WIDTH-2:0], 1'b0};
          end
        end
        WAIT_CS: begin
          if (cs_rise) begin
            tx_done <= 1'b1;
            state   <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
